// File: rtl/log_perf_ctrl.sv
// Log-window and performance-counter control.
// Free-running timer, registered log-window enable, periodic dump generator
// with optional automatic clean, and a dump/clean pulse sequencer.
module log_perf_ctrl #(
    parameter bit          CLEAN_AFTER_DUMP = 1'b1,
    // Reset value of the timer (0 in normal use)
    parameter logic [63:0] TIMER_INIT       = 64'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] log_begin,
    input  logic [63:0] log_end,
    input  logic [31:0] dump_interval,
    input  logic        clean_req,
    input  logic        dump_req,
    output logic [63:0] timer,
    output logic        logEnable,
    output logic        clean,
    output logic        dump
);

    localparam int unsigned TIMER_W = 64;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DUMP  = 2'b01,
        CLEAN = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic               dump_pend_q, dump_pend_d;
    logic               clean_pend_q, clean_pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TIMER_W-1:0] timer_next;
    logic               periodic_ev;
    logic               dump_want;
    logic               clean_want;

    assign timer_next = timer + TIMER_W'(1);

    // Timer and log-window enable; enable is evaluated on the value the timer
    // will show next, so both registers describe the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer     <= TIMER_INIT;
            logEnable <= 1'b0;
        end else begin
            timer     <= timer_next;
            logEnable <= (timer_next >= log_begin) && (timer_next < log_end);
        end
    end

    // A counter already at or beyond the (possibly shrunk) limit fires at once.
    assign periodic_ev = (dump_interval != CNT_W'(0)) &&
                         (cnt_q >= (dump_interval - CNT_W'(1)));

    // Incoming requests are folded into the pending flags in the same cycle so
    // a lone request is issued on the very next edge.
    assign dump_want  = dump_pend_q | dump_req | periodic_ev;
    assign clean_want = clean_pend_q | clean_req | (CLEAN_AFTER_DUMP & periodic_ev);

    // Next-state, pending-flag and interval-counter logic; dump has priority.
    always_comb begin
        state_d      = IDLE;
        dump_pend_d  = dump_want;
        clean_pend_d = clean_want;
        cnt_d        = cnt_q + CNT_W'(1);

        if (dump_want) begin
            state_d     = DUMP;
            dump_pend_d = 1'b0;
        end else if (clean_want) begin
            state_d      = CLEAN;
            clean_pend_d = 1'b0;
        end

        if ((state_d == CLEAN) || periodic_ev || (dump_interval == CNT_W'(0))) begin
            cnt_d = CNT_W'(0);
        end
    end

    // Sequencer state, pending flags and interval counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            dump_pend_q  <= 1'b0;
            clean_pend_q <= 1'b0;
            cnt_q        <= CNT_W'(0);
        end else begin
            state_q      <= state_d;
            dump_pend_q  <= dump_pend_d;
            clean_pend_q <= clean_pend_d;
            cnt_q        <= cnt_d;
        end
    end

    assign dump  = (state_q == DUMP);
    assign clean = (state_q == CLEAN);

endmodule

// File: tb/tb_log_perf_ctrl.sv
// Self-checking bench for log_perf_ctrl: directed scenarios plus randomized
// traffic checked every cycle against a behavioural model.
module tb_log_perf_ctrl;

    localparam logic [63:0] W_START = 64'hFFFF_FFFF_FFFF_FFFD;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] log_begin = 64'd0;
    logic [63:0] log_end = 64'd0;
    logic [31:0] dump_interval = 32'd0;
    logic        clean_req = 1'b0;
    logic        dump_req = 1'b0;

    logic [63:0] timer, w_timer;
    logic        logEnable, clean, dump;
    logic        w_logEnable, w_clean, w_dump;

    log_perf_ctrl dut (
        .clock(clock), .reset(reset), .log_begin(log_begin), .log_end(log_end),
        .dump_interval(dump_interval), .clean_req(clean_req), .dump_req(dump_req),
        .timer(timer), .logEnable(logEnable), .clean(clean), .dump(dump)
    );

    log_perf_ctrl #(.CLEAN_AFTER_DUMP(1'b1), .TIMER_INIT(W_START)) dut_wrap (
        .clock(clock), .reset(reset), .log_begin(log_begin), .log_end(log_end),
        .dump_interval(dump_interval), .clean_req(clean_req), .dump_req(dump_req),
        .timer(w_timer), .logEnable(w_logEnable), .clean(w_clean), .dump(w_dump)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: cycles since reset, expected outputs, owed pulses, interval count.
    logic [63:0] m_timer;
    logic        m_le, m_le_w, m_dump, m_clean;
    logic        m_dump_owed, m_clean_owed;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic in_win(input logic [63:0] t);
        return (t >= log_begin) && (t < log_end);
    endfunction

    task automatic model_reset();
        m_timer = 64'd0; m_le = 1'b0; m_le_w = 1'b0;
        m_dump = 1'b0; m_clean = 1'b0;
        m_dump_owed = 1'b0; m_clean_owed = 1'b0; m_cnt = 32'd0;
    endtask

    // One clock of the behavioural model, using the inputs present at the edge.
    task automatic model_step();
        logic ev, want_dump, want_clean;
        ev = (dump_interval != 0) && (m_cnt + 1 >= dump_interval);
        want_dump  = m_dump_owed || dump_req || ev;
        want_clean = m_clean_owed || clean_req || ev;
        m_dump  = want_dump;
        m_clean = !want_dump && want_clean;
        m_dump_owed  = 1'b0;
        m_clean_owed = want_dump && want_clean;
        if (m_clean || ev || dump_interval == 0) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        m_timer = m_timer + 1;
        m_le   = in_win(m_timer);
        m_le_w = in_win(m_timer + W_START);
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) model_step();
        #1;
    endtask

    task automatic apply_reset();
        dump_req = 1'b0; clean_req = 1'b0;
        reset = 1'b0;
        model_reset();
        step();
        step();
        reset = 1'b1;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        chk("timer", timer, m_timer);
        chk("logEnable", 64'(logEnable), 64'(m_le));
        chk("dump", 64'(dump), 64'(m_dump));
        chk("clean", 64'(clean), 64'(m_clean));
        chk("exclusive", 64'(dump & clean), 64'd0);
        chk("w_timer", w_timer, reset ? m_timer + W_START : W_START);
        chk("w_logEnable", 64'(w_logEnable), 64'(m_le_w));
        chk("w_dump", 64'(w_dump), 64'(m_dump));
        chk("w_clean", 64'(w_clean), 64'(m_clean));
    end

    initial begin
        model_reset();
        #16;

        // Window 10..20 and timer wrap on the preloaded instance.
        log_begin = 64'd10; log_end = 64'd20;
        apply_reset();
        chk("t0_after_release", timer, 64'd0);
        for (int k = 1; k <= 25; k++) begin
            step();
            chk("dir_timer", timer, 64'(k));
            chk("dir_window", 64'(logEnable), 64'((k >= 10) && (k < 20)));
            if (k == 2) chk("wrap_max", w_timer, 64'hFFFF_FFFF_FFFF_FFFF);
            if (k == 3) chk("wrap_zero", w_timer, 64'd0);
        end

        // Inverted window never enables.
        log_begin = 64'd20; log_end = 64'd10;
        apply_reset();
        for (int k = 0; k <= 100; k++) begin
            if (k > 0) step();
            chk("inv_window", 64'(logEnable), 64'd0);
        end

        // Periodic dump every 5 cycles with trailing clean.
        dump_interval = 32'd5;
        apply_reset();
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("per_dump", 64'(dump), 64'((k == 5) || (k == 11)));
            chk("per_clean", 64'(clean), 64'((k == 6) || (k == 12)));
        end

        // Simultaneous requests, then a second dump that pushes the clean back.
        dump_interval = 32'd0;
        apply_reset();
        for (int k = 1; k <= 3; k++) step();
        dump_req = 1'b1; clean_req = 1'b1;
        step();
        chk("both_t4_dump", 64'(dump), 64'd1);
        chk("both_t4_clean", 64'(clean), 64'd0);
        clean_req = 1'b0;
        step();
        chk("b2b_t5_dump", 64'(dump), 64'd1);
        chk("b2b_t5_clean", 64'(clean), 64'd0);
        dump_req = 1'b0;
        step();
        chk("late_t6_clean", 64'(clean), 64'd1);
        chk("late_t6_dump", 64'(dump), 64'd0);
        step();
        chk("quiet_t7", 64'({dump, clean}), 64'd0);

        // Asynchronous reset in the cycle of a dump request discards it.
        log_begin = 64'd0; log_end = 64'd100;
        apply_reset();
        for (int k = 1; k <= 7; k++) step();
        dump_req = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst_timer", timer, 64'd0);
        chk("arst_outs", 64'({logEnable, dump, clean}), 64'd0);
        dump_req = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("arst_no_dump", 64'(dump), 64'd0);
        end

        // Randomized traffic.
        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            dump_req  = ($urandom_range(0, 11) == 0);
            clean_req = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 149) == 0) dump_interval = 32'($urandom_range(0, 12));
            if ($urandom_range(0, 199) == 0) begin
                log_begin = 64'($urandom_range(0, 3500));
                log_end   = 64'($urandom_range(0, 3500));
            end
            if ($urandom_range(0, 799) == 0) apply_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
